// File: rtl/onehot_enc_demux.sv
// One-hot to binary encoder with a small result FIFO and an A/B output demux.
// Define ONEHOT_PRIORITY_EN to accept multi-hot codes (the highest set bit wins).
module onehot_enc_demux #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic [3:0]       Eq_in,
   input  logic             Sel_in,
   input  logic             In_valid,
   output logic             In_ready,
   output logic [1:0]       A_out,
   output logic             A_valid,
   output logic [1:0]       B_out,
   output logic             B_valid,
   input  logic             Out_ready,
   output logic             Err_out,
   output logic [CNT_W-1:0] Err_cnt
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [2:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic [PTR_W:0]   count_nxt;
   logic             ready_q;
   logic             accept;
   logic             legal;
   logic             push;
   logic             pop;
   logic             not_empty;
   logic [1:0]       code;
   logic [2:0]       head;

   function automatic logic [1:0] encode_hi(input logic [3:0] eq);
      logic [1:0] idx;
      idx = 2'b00;
      for (int i = 0; i < 4; i++) begin
         if (eq[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   always_comb begin
`ifdef ONEHOT_PRIORITY_EN
      legal = (Eq_in != 4'b0000);
`else
      legal = ($countones(Eq_in) == 1);
`endif
      code = encode_hi(Eq_in);
   end

   assign accept    = In_valid & ready_q;
   assign push      = accept & legal;
   assign not_empty = (count != '0);
   assign pop       = Out_ready & not_empty;
   assign In_ready  = ready_q;

   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   // Ready is registered from the next occupancy, so it stays low during reset
   // and a pop while full only reopens the input on the following cycle.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         count   <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         ready_q <= 1'b0;
      end else begin
         count   <= count_nxt;
         ready_q <= (count_nxt < FULL_CNT);
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge Clock) begin
      if (push) mem[wr_ptr] <= {Sel_in, code};
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         Err_out <= 1'b0;
         Err_cnt <= '0;
      end else begin
         Err_out <= accept & ~legal;
         if (accept && !legal && (Err_cnt != {CNT_W{1'b1}}))
            Err_cnt <= Err_cnt + CNT_W'(1);
      end
   end

   // Head entry is {sel, code}; the idle channel drives zero.
   always_comb begin
      head    = mem[rd_ptr];
      A_valid = not_empty & ~head[2];
      B_valid = not_empty &  head[2];
      A_out   = A_valid ? head[1:0] : 2'b00;
      B_out   = B_valid ? head[1:0] : 2'b00;
   end

endmodule
